fp_pack: RTL and testbench
==========================

Name: fp_pack

Overview:
- Packs an internal floating-point result into an IEEE-754-style word: sign, EXP_W-bit biased exponent, MAN_W-1-bit fraction.
- Inputs are a sign, a wide signed biased exponent, a mantissa with explicit hidden bit, and special-class flags (NaN/infinite/zero).
- Generates canonical special encodings, saturates overflow to infinity, denormalizes underflow by truncation.
- Sits at the tail of FPU datapaths, after rounding. 2-stage pipeline with valid/ready flow control and sticky exception flags.

Parameters:
- DATA_W, 32, packed word width.
- EXP_W, 8, exponent field width. MAN_W = DATA_W-EXP_W (hidden bit + fraction); bias = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of sticky flags.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input accepted when in_valid & in_ready.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W+2  signed two's-complement biased exponent.
- in_man  in  MAN_W  mantissa; bit MAN_W-1 = hidden bit.
- in_nan  in  1  result is NaN.
- in_inf  in  1  result is infinite.
- in_zero  in  1  result is zero.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  packed word.
- out_overflow  out  1  this beat overflowed.
- out_underflow  out  1  this beat underflowed.
- sticky_overflow  out  1  accumulated overflow.
- sticky_underflow  out  1  accumulated underflow.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids, out_data, out_overflow, out_underflow and the sticky flags go to 0. in_ready is combinational and therefore 1 after reset.
- Flow control:
  - adv = ~out_valid | out_ready; in_ready = adv.
  - Both stages shift only when adv = 1. When adv = 0, every stage register holds its value.
  - Stage-1 valid loads in_valid & in_ready; bubbles propagate.
  - out_data is stable while out_valid & ~out_ready.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later when out_ready is held high. Throughput is 1 beat/cycle.
- Stage 1 (classify) uses a fixed priority:
  1. in_nan: canonical qNaN, sign 0, exponent all ones, fraction MSB 1, rest 0. No flags.
  2. in_inf: {in_sign, all ones, 0}. No flags.
  3. in_zero: {in_sign, 0, 0}. No flags.
  4. in_exp >= 2^EXP_W-1: infinity with in_sign; overflow = 1.
  5. 1 <= in_exp <= 2^EXP_W-2: normal, {in_sign, in_exp[EXP_W-1:0], in_man[MAN_W-2:0]}. The hidden bit is ignored (upstream guarantees normalization).
  6. in_exp <= 0: shift = 1 - in_exp, computed in EXP_W+3 bits.
     - shift >= MAN_W: signed zero.
     - Otherwise: fraction = (in_man >> shift) truncated to MAN_W-1 bits, exponent 0.
     - Underflow = 1 in both sub-cases if in_man != 0.
  - Stage 1 registers the sign, exponent field, shift amount/fraction source and the flags.
- Stage 2 (pack): applies the registered shift, assembles out_data, registers out_overflow/out_underflow.
- Sticky flags:
  - On each transfer (out_valid & out_ready), each sticky flag ORs in the beat's flag.
  - clear = 1 zeroes both sticky flags. If clear coincides with a transfer, the result is the transferring beat's flags (clear first, then set).
  - clear does not affect the pipeline.
- Reset mid-operation drops all in-flight beats; no partial output.

Test Plan:
- Normal: in_sign 0, in_exp 127, in_man 0xC00000, out_ready 1 -> out_data 0x3FC00000 two cycles after acceptance; both per-beat flags 0.
- Overflow: in_exp 255 (and separately 300), sign 1 -> 0xFF800000, out_overflow 1, sticky_overflow 1; clear -> sticky_overflow 0 next cycle.
- Underflow:
  - in_exp 0, in_man 0x800000 -> 0x00400000, out_underflow 1.
  - in_exp -30, sign 1 -> 0x80000000, out_underflow 1.
- Specials:
  - in_nan with sign 1 -> 0x7FC00000.
  - in_inf, sign 0 -> 0x7F800000.
  - in_zero, sign 1 -> 0x80000000; no flags.
  - in_nan & in_inf together -> 0x7FC00000.
- Backpressure: stream 4 beats, hold out_ready 0 for 3 cycles -> in_ready 0, out_data stable; on release, all 4 beats in order with no loss or duplication.
- Reset: assert rst_n low with 2 beats in flight -> out_valid 0 immediately, sticky flags 0, no stale beats after release.

Source files
------------

// File: rtl/fp_pack.sv
// fp_pack: packs a rounded floating-point result into a sign/exponent/fraction
// word through a 2-stage valid/ready pipeline with sticky overflow/underflow.
module fp_pack #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned EXP_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W+1:0]        in_exp,
    input  logic [DATA_W-EXP_W-1:0] in_man,
    input  logic                    in_nan,
    input  logic                    in_inf,
    input  logic                    in_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_overflow,
    output logic                    out_underflow,
    output logic                    sticky_overflow,
    output logic                    sticky_underflow
);

    localparam int unsigned MAN_W  = DATA_W - EXP_W;
    localparam int unsigned FRAC_W = MAN_W - 1;
    localparam int unsigned EXPI_W = EXP_W + 2;
    localparam int unsigned SHF_W  = EXP_W + 3;
    localparam int unsigned SH_W   = $clog2(MAN_W);

    localparam logic signed [EXPI_W-1:0] EXP_INF  = EXPI_W'(2**EXP_W - 1);
    localparam logic signed [EXPI_W-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0]         EXP_ONES = '1;
    localparam logic [MAN_W-1:0]         QNAN_MAN = MAN_W'(1) << (MAN_W - 2);

    // Both stages move together; a full, stalled output freezes the pipe.
    logic adv;
    logic xfer;

    logic signed [EXPI_W-1:0] exp_s;
    logic signed [SHF_W-1:0]  shift_full;

    logic               s1_sign_d;
    logic [EXP_W-1:0]   s1_exp_d;
    logic [MAN_W-1:0]   s1_man_d;
    logic [SH_W-1:0]    s1_shift_d;
    logic               s1_ovf_d;
    logic               s1_unf_d;

    logic               s1_valid_q;
    logic               s1_sign_q;
    logic [EXP_W-1:0]   s1_exp_q;
    logic [MAN_W-1:0]   s1_man_q;
    logic [SH_W-1:0]    s1_shift_q;
    logic               s1_ovf_q;
    logic               s1_unf_q;

    logic [FRAC_W-1:0]  frac_d;
    logic [DATA_W-1:0]  out_data_d;

    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               out_ovf_q;
    logic               out_unf_q;
    logic               sticky_ovf_q;
    logic               sticky_unf_q;

    assign adv        = ~out_valid_q | out_ready;
    assign in_ready   = adv;
    assign xfer       = out_valid_q & out_ready;
    assign exp_s      = in_exp;
    assign shift_full = SHF_W'(1) - SHF_W'(exp_s);

    // Stage-1 classification in fixed priority: NaN, Inf, zero, overflow, normal, subnormal.
    always_comb begin
        s1_sign_d  = in_sign;
        s1_exp_d   = '0;
        s1_man_d   = '0;
        s1_shift_d = '0;
        s1_ovf_d   = 1'b0;
        s1_unf_d   = 1'b0;
        if (in_nan) begin
            s1_sign_d = 1'b0;
            s1_exp_d  = EXP_ONES;
            s1_man_d  = QNAN_MAN;
        end else if (in_inf) begin
            s1_exp_d = EXP_ONES;
        end else if (in_zero) begin
            s1_exp_d = '0;
        end else if (exp_s >= EXP_INF) begin
            s1_exp_d = EXP_ONES;
            s1_ovf_d = 1'b1;
        end else if (exp_s > EXP_ZERO) begin
            s1_exp_d = in_exp[EXP_W-1:0];
            s1_man_d = in_man;
        end else begin
            // Denormalize by truncation; shifts past the mantissa flush to signed zero.
            s1_unf_d = |in_man;
            if ($unsigned(shift_full) < SHF_W'(MAN_W)) begin
                s1_man_d   = in_man;
                s1_shift_d = SH_W'(shift_full);
            end
        end
    end

    // Stage-2 pack: apply the registered shift and assemble the word.
    always_comb begin
        frac_d     = FRAC_W'(s1_man_q >> s1_shift_q);
        out_data_d = {s1_sign_q, s1_exp_q, frac_d};
    end

    // Stage-1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_man_q   <= '0;
            s1_shift_q <= '0;
            s1_ovf_q   <= 1'b0;
            s1_unf_q   <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid & in_ready;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_man_q   <= s1_man_d;
            s1_shift_q <= s1_shift_d;
            s1_ovf_q   <= s1_ovf_d;
            s1_unf_q   <= s1_unf_d;
        end
    end

    // Output stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            out_data_q  <= out_data_d;
            out_ovf_q   <= s1_ovf_q;
            out_unf_q   <= s1_unf_q;
        end
    end

    // Sticky flags: clear takes effect before the transferring beat sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            sticky_ovf_q <= (clear ? 1'b0 : sticky_ovf_q) | (xfer & out_ovf_q);
            sticky_unf_q <= (clear ? 1'b0 : sticky_unf_q) | (xfer & out_unf_q);
        end
    end

    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_overflow     = out_ovf_q;
    assign out_underflow    = out_unf_q;
    assign sticky_overflow  = sticky_ovf_q;
    assign sticky_underflow = sticky_unf_q;

endmodule

// File: tb/tb_fp_pack.sv
// Testbench for fp_pack: scoreboarded streams plus directed latency/sticky/reset scenarios.
module tb_fp_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [23:0] in_man = '0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_overflow;
    logic        out_underflow;
    logic        sticky_overflow;
    logic        sticky_underflow;

    typedef struct { logic [31:0] data; logic ovf; logic unf; } exp_t;
    typedef struct { logic s; int e; logic [23:0] m; logic n; logic i; logic z; } beat_t;

    exp_t  sb[$];
    beat_t vb[$];
    exp_t  ve[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    fp_pack #(.DATA_W(32), .EXP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_overflow(out_overflow), .out_underflow(out_underflow),
        .sticky_overflow(sticky_overflow), .sticky_underflow(sticky_underflow)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(logic s, int e, logic [23:0] m, logic n, logic i, logic z);
        beat_t b;
        b.s = s; b.e = e; b.m = m; b.n = n; b.i = i; b.z = z;
        return b;
    endfunction

    // Reference model written in integer arithmetic.
    function automatic exp_t model(beat_t b);
        exp_t r;
        int sh;
        logic [23:0] t;
        logic [7:0] ef;
        r.ovf = 1'b0; r.unf = 1'b0;
        if (b.n)             r.data = 32'h7FC00000;
        else if (b.i)        r.data = {b.s, 8'hFF, 23'h0};
        else if (b.z)        r.data = {b.s, 31'h0};
        else if (b.e >= 255) begin r.data = {b.s, 8'hFF, 23'h0}; r.ovf = 1'b1; end
        else if (b.e >= 1)   begin ef = 8'(b.e); r.data = {b.s, ef, b.m[22:0]}; end
        else begin
            sh = 1 - b.e;
            r.unf = (b.m != 0);
            t = (sh >= 24) ? 24'h0 : (b.m >> sh);
            r.data = {b.s, 8'h00, t[22:0]};
        end
        return r;
    endfunction

    task automatic drive(beat_t b);
        in_sign = b.s; in_exp = 10'(b.e); in_man = b.m;
        in_nan = b.n; in_inf = b.i; in_zero = b.z;
    endtask

    task automatic add(beat_t b, logic [31:0] d, logic o, logic u);
        exp_t e;
        e.data = d; e.ovf = o; e.unf = u;
        vb.push_back(b); ve.push_back(e);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        n_checks++; if ({sticky_overflow, sticky_underflow, out_overflow, out_underflow} !== 4'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {sticky_overflow, sticky_underflow, out_overflow, out_underflow}); end
        rst_n = 1'b1;
    endtask

    task automatic test_encodings();
        int k = 0;
        int budget = 200;
        vb.delete(); ve.delete();
        add(mk(0, 127,  24'hC00000, 0, 0, 0), 32'h3FC00000, 0, 0);
        add(mk(1, 255,  24'h800000, 0, 0, 0), 32'hFF800000, 1, 0);
        add(mk(1, 300,  24'h800000, 0, 0, 0), 32'hFF800000, 1, 0);
        add(mk(0, 0,    24'h800000, 0, 0, 0), 32'h00400000, 0, 1);
        add(mk(1, -30,  24'h800000, 0, 0, 0), 32'h80000000, 0, 1);
        add(mk(1, 5,    24'h812345, 1, 0, 0), 32'h7FC00000, 0, 0);
        add(mk(0, 5,    24'h812345, 0, 1, 0), 32'h7F800000, 0, 0);
        add(mk(1, 5,    24'h812345, 0, 0, 1), 32'h80000000, 0, 0);
        add(mk(0, 300,  24'h812345, 1, 1, 0), 32'h7FC00000, 0, 0);
        add(mk(0, 254,  24'hFFFFFF, 0, 0, 0), 32'h7F7FFFFF, 0, 0);
        add(mk(0, 1,    24'h800000, 0, 0, 0), 32'h00800000, 0, 0);
        add(mk(0, -22,  24'hFFFFFF, 0, 0, 0), 32'h00000001, 0, 1);
        add(mk(0, -23,  24'hFFFFFF, 0, 0, 0), 32'h00000000, 0, 1);
        add(mk(0, 0,    24'h000000, 0, 0, 0), 32'h00000000, 0, 0);
        add(mk(1, -512, 24'h000001, 0, 0, 0), 32'h80000000, 0, 1);
        add(mk(0, 511,  24'h800000, 0, 0, 0), 32'h7F800000, 1, 0);
        while ((k < vb.size() || sb.size() > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            out_ready = 1'b1;
            if (k < vb.size()) begin drive(vb[k]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin n_checks++; n_fail++; $display("FAIL enc_spurious: got beat %h, expected none", out_data); end
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_checks++; if (out_data !== e.data) begin n_fail++; $display("FAIL enc_data: got %h expected %h", out_data, e.data); end
                    n_checks++; if (out_overflow !== e.ovf) begin n_fail++; $display("FAIL enc_ovf: got %b expected %b (data %h)", out_overflow, e.ovf, e.data); end
                    n_checks++; if (out_underflow !== e.unf) begin n_fail++; $display("FAIL enc_unf: got %b expected %b (data %h)", out_underflow, e.unf, e.data); end
                end
            end
            if (in_valid && in_ready) begin sb.push_back(ve[k]); k++; end
        end
        in_valid = 1'b0;
        if (budget == 0) begin n_checks++; n_fail++; $display("FAIL enc_timeout: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        out_ready = 1'b1;
        drive(mk(0, 127, 24'hC00000, 0, 0, 0));
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1: got out_valid %b expected 0", out_valid); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_cycle2: got out_valid %b expected 1", out_valid); end
        n_checks++; if (out_data !== 32'h3FC00000) begin n_fail++; $display("FAIL lat_data: got %h expected 3fc00000", out_data); end
        n_checks++; if ({out_overflow, out_underflow} !== 2'b00) begin n_fail++; $display("FAIL lat_flags: got %b expected 00", {out_overflow, out_underflow}); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_sticky();
        @(negedge clk);
        out_ready = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++; if ({sticky_overflow, sticky_underflow} !== 2'b00) begin n_fail++; $display("FAIL sticky_clear_both: got %b expected 00", {sticky_overflow, sticky_underflow}); end
        drive(mk(1, 300, 24'h800000, 0, 0, 0)); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_data !== 32'hFF800000 || out_overflow !== 1'b1) begin n_fail++; $display("FAIL sticky_ovf_beat: got %h/%b expected ff800000/1", out_data, out_overflow); end
        @(negedge clk);
        n_checks++; if ({sticky_overflow, sticky_underflow} !== 2'b10) begin n_fail++; $display("FAIL sticky_set: got %b expected 10", {sticky_overflow, sticky_underflow}); end
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        n_checks++; if (sticky_overflow !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b expected 0", sticky_overflow); end
        drive(mk(1, 255, 24'h800000, 0, 0, 0)); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sticky_overflow !== 1'b1) begin n_fail++; $display("FAIL sticky_reset_ovf: got %b expected 1", sticky_overflow); end
        drive(mk(0, 0, 24'h800000, 0, 0, 0)); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        n_checks++; if ({sticky_overflow, sticky_underflow} !== 2'b01) begin n_fail++; $display("FAIL sticky_clear_with_xfer: got %b expected 01", {sticky_overflow, sticky_underflow}); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int got = 0;
        int cyc = 0;
        logic [31:0] held = '0;
        vb.delete(); ve.delete();
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b = mk(i[0], 100 + i, 24'h800000 | 24'(i * 24'h1111), 0, 0, 0);
            add(b, model(b).data, 0, 0);
        end
        while ((k < 4 || sb.size() > 0) && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 1 && cyc <= 3);
            if (k < 4) begin drive(vb[k]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (cyc == 2) begin
                held = out_data;
                n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall2: got in_ready %b out_valid %b expected 0 1", in_ready, out_valid); end
            end
            if (cyc == 3) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall3: got in_ready %b expected 0", in_ready); end
                n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", out_data, held); end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin n_checks++; n_fail++; $display("FAIL bp_spurious: got beat %h, expected none", out_data); end
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    got++;
                    n_checks++; if (out_data !== e.data) begin n_fail++; $display("FAIL bp_order: got %h expected %h", out_data, e.data); end
                end
            end
            if (in_valid && in_ready) begin sb.push_back(ve[k]); k++; end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (got !== 4) begin n_fail++; $display("FAIL bp_count: got %0d beats expected 4", got); end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int budget = 1000;
        vb.delete(); ve.delete();
        for (int i = 0; i < 40; i++) begin
            beat_t b;
            int r;
            r = int'($urandom_range(0, 15));
            b = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 580)) - 300,
                   24'($urandom) | 24'h800000, r == 0, r == 1, r == 2);
            if (r == 3) b.m = 24'($urandom);
            add(b, model(b).data, model(b).ovf, model(b).unf);
        end
        while ((k < vb.size() || sb.size() > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            out_ready = ($urandom_range(0, 3) != 0);
            if (k < vb.size() && $urandom_range(0, 4) != 0) begin drive(vb[k]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin n_checks++; n_fail++; $display("FAIL b2b_spurious: got beat %h, expected none", out_data); end
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_checks++; if ({out_data, out_overflow, out_underflow} !== {e.data, e.ovf, e.unf})
                        begin n_fail++; $display("FAIL b2b_beat: got %h/%b%b expected %h/%b%b", out_data, out_overflow, out_underflow, e.data, e.ovf, e.unf); end
                end
            end
            if (in_valid && in_ready) begin sb.push_back(ve[k]); k++; end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (budget == 0) begin n_checks++; n_fail++; $display("FAIL b2b_timeout: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b1;
        drive(mk(1, 300, 24'h800000, 0, 0, 0)); in_valid = 1'b1;
        @(negedge clk);
        drive(mk(0, 0, 24'h800000, 0, 0, 0)); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_precond: got out_valid %b expected 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        n_checks++; if ({sticky_overflow, sticky_underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_async_sticky: got %b expected 00", {sticky_overflow, sticky_underflow}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale_beat: got out_valid %b expected 0 (cycle %0d)", out_valid, i); end
        end
    endtask

    initial begin
        test_reset();
        test_encodings();
        test_latency();
        test_sticky();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
